// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// The prefix states exist only when UART_ARB_PREFIX_EN is defined.
package uart_arb_pkg;

  localparam int         IDLE_CNT_W  = 16;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_STREAM    = 2'd1
`ifdef UART_ARB_PREFIX_EN
    ,
    ST_PFX_ID    = 2'd2,
    ST_PFX_COLON = 2'd3
`endif
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// UART transmit FIFO write port: the arbiter drives data/strobe, the FIFO returns full.
interface uart_tx_arbiter_if;

  logic [31:0] uart_wdata;
  logic        uart_we;
  logic        uart_full;

  modport master (output uart_wdata, output uart_we, input uart_full);
  modport slave  (input uart_wdata, input uart_we, output uart_full);

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotated priority encoder: first set request at or after start, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  start,
  output logic            valid,
  output logic [IDW-1:0]  idx
);

  logic [IDW-1:0] cand_s;

  // Scan from the farthest slot back to start so the nearest hit is written last.
  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    cand_s = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand_s = IDW'((int'(start) + k) % NREQ);
      valid  = req[cand_s] ? 1'b1   : valid;
      idx    = req[cand_s] ? cand_s : idx;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Line-granular round-robin arbiter in front of the UART transmit FIFO write port.
// Define UART_ARB_PREFIX_EN to emit "<id>:" ahead of every granted line.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [8*NREQ-1:0]     req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy,
  uart_tx_arbiter_if.master     bus
);

  arb_state_e            state_q;
  logic [IDW-1:0]        grant_id_q;
  logic [IDW-1:0]        rr_ptr_q;
  logic [IDLE_CNT_W-1:0] idle_cnt_q;

  logic [7:0]            req_byte_s [NREQ];
  logic [7:0]            sel_byte_s;
  logic                  sel_valid_s;
  logic                  accept_s;
  logic                  pick_valid_s;
  logic [IDW-1:0]        pick_idx_s;
  logic [IDW-1:0]        rr_next_s;
  logic [IDLE_CNT_W-1:0] idle_cnt_d;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req   (req_valid),
    .start (rr_ptr_q),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  // Split the flat data bus into per-requester bytes.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_byte_s[i] = req_data[8*i +: 8];
    end
  end

  assign sel_byte_s  = req_byte_s[grant_id_q];
  assign sel_valid_s = req_valid[grant_id_q];
  assign accept_s    = (state_q == ST_STREAM) && sel_valid_s && !bus.uart_full;
  assign rr_next_s   = (grant_id_q == IDW'(NREQ - 1)) ? '0 : grant_id_q + IDW'(1);
  assign idle_cnt_d  = (idle_cnt_q == {IDLE_CNT_W{1'b1}}) ? idle_cnt_q
                                                          : idle_cnt_q + IDLE_CNT_W'(1);
  assign busy        = (state_q != ST_IDLE);
  assign grant_id    = grant_id_q;

  // Write-port mux: grantee bytes in STREAM, generated prefix bytes otherwise.
  always_comb begin
    req_ready      = '0;
    bus.uart_we    = 1'b0;
    bus.uart_wdata = 32'h0000_0000;
    case (state_q)
      ST_STREAM: begin
        req_ready[grant_id_q] = accept_s;
        bus.uart_we           = accept_s;
        bus.uart_wdata        = {24'h00_0000, sel_byte_s};
      end
`ifdef UART_ARB_PREFIX_EN
      ST_PFX_ID: begin
        bus.uart_we    = !bus.uart_full;
        bus.uart_wdata = {24'h00_0000, ASCII_ZERO + 8'(grant_id_q)};
      end
      ST_PFX_COLON: begin
        bus.uart_we    = !bus.uart_full;
        bus.uart_wdata = {24'h00_0000, ASCII_COLON};
      end
`endif
      default: begin
        bus.uart_we = 1'b0;
      end
    endcase
  end

  // Grant FSM, round-robin pointer and idle watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      idle_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid_s) begin
            grant_id_q <= pick_idx_s;
            idle_cnt_q <= '0;
`ifdef UART_ARB_PREFIX_EN
            state_q    <= ST_PFX_ID;
`else
            state_q    <= ST_STREAM;
`endif
          end else begin
            state_q <= ST_IDLE;
          end
        end
`ifdef UART_ARB_PREFIX_EN
        ST_PFX_ID: begin
          state_q <= bus.uart_full ? ST_PFX_ID : ST_PFX_COLON;
        end
        ST_PFX_COLON: begin
          state_q <= bus.uart_full ? ST_PFX_COLON : ST_STREAM;
        end
`endif
        ST_STREAM: begin
          if (accept_s) begin
            idle_cnt_q <= '0;
            if (sel_byte_s == ASCII_LF) begin
              state_q  <= ST_IDLE;
              rr_ptr_q <= rr_next_s;
            end else begin
              state_q  <= ST_STREAM;
            end
          end else if (!sel_valid_s) begin
            // Only a silent grantee ages the watchdog; a full FIFO never does.
            idle_cnt_q <= idle_cnt_d;
            if (idle_cnt_d == IDLE_CNT_W'(TIMEOUT)) begin
              state_q  <= ST_IDLE;
              rr_ptr_q <= rr_next_s;
            end else begin
              state_q  <= ST_STREAM;
            end
          end else begin
            state_q <= ST_STREAM;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NREQ=4, TIMEOUT=8); prefix bytes are
// expected only when UART_ARB_PREFIX_EN is defined.
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 8;
  localparam int IDW     = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_valid;
  logic [31:0]     req_data;
  logic [NREQ-1:0] req_ready;
  logic [IDW-1:0]  grant_id;
  logic            busy;
  int              n_cmp  = 0;
  int              n_fail = 0;

  uart_tx_arbiter_if u_if ();

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .bus       (u_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "bench timed out");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_byte(input int i, input logic [7:0] b);
    req_data[8*i +: 8] = b;
  endtask

  // One accepted byte from requester id this cycle.
  task automatic chk_write(input string tag, input int id, input logic [7:0] b);
    chk({tag, "_we"},    32'(u_if.uart_we), 32'd1);
    chk({tag, "_wdata"}, u_if.uart_wdata, {24'd0, b});
    chk({tag, "_ready"}, 32'(req_ready), 32'(1) << id);
    chk({tag, "_gid"},   32'(grant_id), 32'(id));
  endtask

  task automatic pfx(input string tag, input int id);
`ifdef UART_ARB_PREFIX_EN
    settle();
    chk({tag, "_pid_we"},    32'(u_if.uart_we), 32'd1);
    chk({tag, "_pid_wdata"}, u_if.uart_wdata, 32'h30 + 32'(id));
    chk({tag, "_pid_ready"}, 32'(req_ready), 32'd0);
    tick();
    settle();
    chk({tag, "_pcol_we"},    32'(u_if.uart_we), 32'd1);
    chk({tag, "_pcol_wdata"}, u_if.uart_wdata, 32'h3A);
    tick();
`else
    begin end
`endif
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_we"},   32'(u_if.uart_we), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; u_if.uart_full = 1'b0;
    tick(); tick();
    settle();
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_gid",   32'(grant_id), 32'd0);
    chk("rst_we",    32'(u_if.uart_we), 32'd0);
    chk("rst_wdata", u_if.uart_wdata, 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);

    // Single line from req0: 41 42 0A.
    rst = 1'b0; req_valid = 4'b0001; set_byte(0, 8'h41);
    settle(); chk_idle("t1_req");
    tick(); pfx("t1", 0);
    settle(); chk_write("t1_b0", 0, 8'h41); chk("t1_busy", 32'(busy), 32'd1);
    tick(); set_byte(0, 8'h42); settle(); chk_write("t1_b1", 0, 8'h42);
    tick(); set_byte(0, 8'h0A); settle(); chk_write("t1_b2", 0, 8'h0A);
    tick(); req_valid = '0; settle(); chk_idle("t1_done");

    // req0 and req1 both want to send "a\n" straight out of reset.
    rst = 1'b1; tick(); rst = 1'b0;
    req_valid = 4'b0011; set_byte(0, 8'h61); set_byte(1, 8'h61);
    settle(); chk_idle("t2_req");
    tick(); pfx("t2a", 0);
    settle(); chk_write("t2_r0a", 0, 8'h61);
    tick(); set_byte(0, 8'h0A); settle(); chk_write("t2_r0lf", 0, 8'h0A);
    tick(); req_valid = 4'b0010; settle(); chk_idle("t2_gap");
    tick(); pfx("t2b", 1);
    settle(); chk_write("t2_r1a", 1, 8'h61);
    tick(); set_byte(1, 8'h0A); settle(); chk_write("t2_r1lf", 1, 8'h0A);
    tick(); req_valid = 4'b0101; set_byte(0, 8'h55); set_byte(2, 8'h77);
    settle(); chk_idle("t2_done");
    // Pointer now at 2, so req2 beats req0.
    tick(); pfx("t2c", 2);
    settle(); chk_write("t2_ptr2", 2, 8'h77);

    // FIFO full for longer than TIMEOUT while the grantee keeps its byte valid.
    tick(); set_byte(2, 8'h78); u_if.uart_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("t3_stall_we",    32'(u_if.uart_we), 32'd0);
      chk("t3_stall_ready", 32'(req_ready), 32'd0);
      chk("t3_stall_busy",  32'(busy), 32'd1);
      tick();
    end
    u_if.uart_full = 1'b0; settle(); chk_write("t3_resume", 2, 8'h78);
    tick(); set_byte(2, 8'h0A); settle(); chk_write("t3_lf", 2, 8'h0A);
    tick(); req_valid = 4'b0001; settle(); chk_idle("t3_done");
    tick(); pfx("t3", 0);
    settle(); chk_write("t3_wrap_r0", 0, 8'h55);
    tick(); set_byte(0, 8'h0A); settle(); chk_write("t3_r0lf", 0, 8'h0A);
    tick(); req_valid = 4'b0110; set_byte(1, 8'h78); set_byte(2, 8'h5A);
    settle(); chk_idle("t3_end");

    // req1 sends one byte then goes quiet; req2 waits for the timeout.
    tick(); pfx("t4", 1);
    settle(); chk_write("t4_r1", 1, 8'h78);
    tick(); req_valid = 4'b0100;
    for (int i = 0; i < TIMEOUT; i++) begin
      settle();
      chk("t4_hold_busy",  32'(busy), 32'd1);
      chk("t4_hold_ready", 32'(req_ready), 32'd0);
      tick();
    end
    settle(); chk_idle("t4_release");
    tick(); pfx("t4b", 2);
    settle(); chk_write("t4_r2", 2, 8'h5A);
    tick(); set_byte(2, 8'h0A); settle(); chk_write("t4_r2lf", 2, 8'h0A);
    tick(); req_valid = 4'b1000; set_byte(3, 8'h31); settle(); chk_idle("t4_done");

    // Reset in the middle of req3's line.
    tick(); pfx("t5", 3);
    settle(); chk_write("t5_r3", 3, 8'h31);
    tick(); set_byte(3, 8'h32); rst = 1'b1;
    tick(); rst = 1'b0; req_valid = 4'b0011; set_byte(0, 8'h40); set_byte(1, 8'h41);
    settle();
    chk("t5_rst_busy",  32'(busy), 32'd0);
    chk("t5_rst_gid",   32'(grant_id), 32'd0);
    chk("t5_rst_we",    32'(u_if.uart_we), 32'd0);
    chk("t5_rst_wdata", u_if.uart_wdata, 32'd0);
    chk("t5_rst_ready", 32'(req_ready), 32'd0);
    tick(); pfx("t5b", 0);
    settle(); chk_write("t5_r0", 0, 8'h40);
    tick(); set_byte(0, 8'h0A); settle(); chk_write("t5_r0lf", 0, 8'h0A);
    tick(); req_valid = '0; settle(); chk_idle("t5_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmit FIFO write port among `NREQ` byte-stream requesters (CPU core, debug monitor, trace unit). Line-granular round-robin arbitration: a granted requester keeps the port until it sends a line feed or goes idle too long, so text lines from different sources never interleave. Sits between the requesters and the UART write port (`wdata`/`we`/`full`).

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..10.
- `TIMEOUT`, 1023: idle cycles (grantee `req_valid` low) before forced release, 1..65535.
- `IDW`, `$clog2(NREQ)`: width of `grant_id`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NREQ  per-requester byte valid.
- `req_data`  in  8*NREQ  per-requester byte; requester i uses bits [8i+7:8i].
- `req_ready`  out  NREQ  per-requester byte accepted this cycle.
- `uart_wdata`  out  32  to UART `wdata`; upper 24 bits always 0.
- `uart_we`  out  1  to UART `we`.
- `uart_full`  in  1  from UART `full`.
- `grant_id`  out  IDW  current or last grantee.
- `busy`  out  1  a requester holds the port.

## Operation
- States: IDLE, PFX_ID, PFX_COLON, STREAM. PFX_* exist only with `UART_ARB_PREFIX_EN`.
- IDLE: if any `req_valid`, choose the first set bit at or after `rr_ptr`, wrapping modulo NREQ. Load `grant_id` and go to PFX_ID (or STREAM). Otherwise stay in IDLE.
- STREAM:
  - `req_ready[grant_id] = req_valid[grant_id] & ~uart_full`. All other `req_ready` bits are 0.
  - `uart_we = req_ready[grant_id]`; `uart_wdata = {24'b0, req_data[grant_id]}`. Both are combinational.
- Release: the accepted byte is 8'h0A, or the idle counter reaches TIMEOUT. On release: IDLE, `rr_ptr <= (grant_id+1) mod NREQ`, `busy` falls.
- Idle counter:
  - Clears on grant and on every accepted byte.
  - Increments each STREAM cycle with `req_valid[grant_id]` low.
  - Holds while `req_valid` is high and `uart_full` stalls. Back-pressure never causes release.
  - Width 16 bits, saturating.
- Non-granted requesters wait with `req_ready` low; their bytes are never dropped.
- `busy` = state != IDLE.
- `grant_id` holds its last value in IDLE.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, `grant_id` 0, `busy` 0, idle counter 0, `req_ready` 0, `uart_we` 0, `uart_wdata` 0.
- Arbitration latency: request seen in IDLE at cycle t; grant registered at t+1. First byte is accepted at t+1 at the earliest (t+3 with prefix).
- Throughput: one byte per cycle while `uart_full` is low.
- `uart_full` is sampled in the same cycle as `uart_we`. The UART updates `full` one cycle after a write, so `uart_we` never asserts while `full` is high.
- Line feed accepted at cycle c: IDLE at c+1; next grant at c+2.
- Timeout: release on the cycle the counter equals TIMEOUT.
- `rst` mid-line: all state returns to reset values on the next edge; any partial line is abandoned.
- Request dropped during IDLE before the grant registers: the grant still occurs and the timeout handles release.

## Configuration
- `UART_ARB_PREFIX_EN` defined: each grant first writes ASCII `'0'+grant_id` (PFX_ID), then 8'h3A `':'` (PFX_COLON), then enters STREAM.
  - Each prefix byte waits for `~uart_full`.
  - Requester `req_ready` stays 0 during prefix states.
  - The idle counter does not run during prefix states.
- Undefined: IDLE goes directly to STREAM; no prefix bytes; PFX states absent.

## Structure
- Package `uart_arb_pkg`:
  - State enum.
  - Constants `ASCII_LF`=8'h0A, `ASCII_COLON`=8'h3A, `ASCII_ZERO`=8'h30.
  - Idle counter width 16.
- Sub-module `rr_pick`: rotated priority encoder; inputs `req[NREQ]`, `start[IDW]`; outputs `valid`, `idx`. Purely combinational.
- Top module holds the FSM, idle counter, `rr_ptr` and the output muxing.

## Test plan
- Req0 sends 41,42,0A with `uart_full`=0 → `uart_we` on 3 consecutive cycles starting 1 cycle after `req_valid`; `wdata` 41,42,0A; then `busy`=0.
- Req0 and req1 both valid from reset, each sending "a\n" → full line from req0 (61,0A), then req1 (61,0A); `rr_ptr` ends at 2.
- `uart_full` held high 5 cycles mid-line with `req_valid` high → `uart_we`=0 and `req_ready`=0 for 5 cycles; no release with TIMEOUT=4; line completes afterwards.
- TIMEOUT=8: req1 sends 78 then drops valid while req2 waits → release exactly 8 cycles after the last accept; req2 granted next.
- `UART_ARB_PREFIX_EN`: req2 sends "hi\n" → `wdata` sequence 32,3A,68,69,0A.
- `rst` pulsed after 1 of 3 bytes → all outputs 0 the next cycle; a subsequent request from req1 and req0 grants req0 first.
